// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM port arbiter.
// Master IDs double as the read-pending owner tag.
package sram_arb_pkg;

  localparam int DW = 32;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_LDR = 1'b1
  } mst_e;

  typedef struct packed {
    logic valid;
    mst_e owner;
  } rd_pend_t;

  localparam rd_pend_t RD_PEND_IDLE = '{valid: 1'b0, owner: MST_CPU};

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int cnt_width(input int limit);
    if (limit < 1) begin
      return 1;
    end else begin
      return $clog2(limit + 1);
    end
  endfunction

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Saturating count of consecutive cycles in which M1 requests but is denied.
// force_m1 is raised once the count reaches STARVE_LIMIT.
module sram_arb_starve_ctr
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = cnt_width(STARVE_LIMIT)
) (
  input  logic clka,
  input  logic rstb,
  input  logic m1_req,
  input  logic m1_gnt,
  output logic force_m1
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_d;
  logic [CW-1:0] starve_cnt_q;

  // Next count: clear on grant or idle request, otherwise count up to the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || m1_gnt) begin
      starve_cnt_d = {CW{1'b0}};
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clka or negedge rstb) begin
    if (!rstb) begin
      starve_cnt_q <= {CW{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign force_m1 = (starve_cnt_q == LIMIT);

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter for a simple dual-port SRAM (one write port, one read port).
// M0 has priority; M1 is forced through after STARVE_LIMIT denied cycles.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          clka,
  input  logic          rstb,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          sram_wea,
  output logic [AW-1:0] sram_waddr,
  output logic [DW-1:0] sram_dina,
  output logic [AW-1:0] sram_addra,
  input  logic [DW-1:0] sram_douta
);

  logic          force_m1;
  logic          gnt_any;
  mst_e          gnt_owner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          wr_go;
  logic          rd_go;

  logic [AW-1:0] waddr_d, waddr_q;
  logic [DW-1:0] wdata_d, wdata_q;
  logic [AW-1:0] raddr_d, raddr_q;
  rd_pend_t      rd_pend_d, rd_pend_q;

  sram_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clka     (clka),
    .rstb     (rstb),
    .m1_req   (m1_req),
    .m1_gnt   (m1_gnt),
    .force_m1 (force_m1)
  );

  // Grant decision; reset is folded in so no grant can leak out while rstb is low.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rstb) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end else if (m1_req && (!m0_req || force_m1)) begin
      m1_gnt = 1'b1;
    end else if (m0_req) begin
      m0_gnt = 1'b1;
    end else begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

  // Select the granted master's request fields.
  always_comb begin
    gnt_any   = m0_gnt | m1_gnt;
    gnt_owner = m1_gnt ? MST_LDR : MST_CPU;
    case (gnt_owner)
      MST_CPU: begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
      end
      MST_LDR: begin
        sel_we    = m1_we;
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
      end
      default: begin
        sel_we    = 1'b0;
        sel_addr  = {AW{1'b0}};
        sel_wdata = {DW{1'b0}};
      end
    endcase
  end

  // SRAM side: pass granted fields through, otherwise hold the last granted ones.
  always_comb begin
    wr_go     = gnt_any & sel_we;
    rd_go     = gnt_any & ~sel_we;
    waddr_d   = wr_go ? sel_addr : waddr_q;
    wdata_d   = wr_go ? sel_wdata : wdata_q;
    raddr_d   = rd_go ? sel_addr : raddr_q;
    rd_pend_d = '{valid: rd_go, owner: gnt_owner};
  end

  // Hold registers and read-pending tag.
  always_ff @(posedge clka or negedge rstb) begin
    if (!rstb) begin
      waddr_q   <= {AW{1'b0}};
      wdata_q   <= {DW{1'b0}};
      raddr_q   <= {AW{1'b0}};
      rd_pend_q <= RD_PEND_IDLE;
    end else begin
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign sram_wea   = wr_go;
  assign sram_waddr = waddr_d;
  assign sram_dina  = wdata_d;
  assign sram_addra = raddr_d;

  // Read return: steer SRAM data to the owner of last cycle's read, zero elsewhere.
  always_comb begin
    m0_rvalid = rd_pend_q.valid && (rd_pend_q.owner == MST_CPU);
    m1_rvalid = rd_pend_q.valid && (rd_pend_q.owner == MST_LDR);
    m0_rdata  = m0_rvalid ? sram_douta : {DW{1'b0}};
    m1_rdata  = m1_rvalid ? sram_douta : {DW{1'b0}};
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: stimulus pushes expected read returns into
// per-master queues, a negedge monitor pops and compares them.
module tb_sram_arbiter;

  localparam int AW = 32;

  logic          clka = 1'b0;
  logic          rstb = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_wea;
  logic [AW-1:0] sram_waddr, sram_addra;
  logic [31:0]   sram_dina;
  logic [31:0]   sram_douta = 32'h0;

  always #5 clka = ~clka;

  sram_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
    .clka(clka), .rstb(rstb),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .sram_wea(sram_wea), .sram_waddr(sram_waddr), .sram_dina(sram_dina),
    .sram_addra(sram_addra), .sram_douta(sram_douta)
  );

  // SRAM model: registered read, write commits at the edge.
  logic [31:0] mem [0:255] = '{default: 32'h0};
  always @(posedge clka) begin
    if (sram_wea) mem[sram_waddr[7:0]] <= sram_dina;
    sram_douta <= mem[sram_addra[7:0]];
  end

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] exp_mem [0:255] = '{default: 32'h0};
  logic [31:0] last_w = 32'h0, last_d = 32'h0, last_r = 32'h0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: rvalid must appear exactly on the due cycle with the queued data.
  always @(negedge clka) begin
    logic v0e, v1e;
    v0e = (q0.size() > 0) && (q0[0].due == cyc);
    v1e = (q1.size() > 0) && (q1[0].due == cyc);
    chk("m0_rvalid", {31'h0, m0_rvalid}, {31'h0, v0e});
    chk("m1_rvalid", {31'h0, m1_rvalid}, {31'h0, v1e});
    if (v0e) begin
      chk("m0_rdata", m0_rdata, q0[0].data);
      void'(q0.pop_front());
    end else begin
      chk("m0_rdata_idle", m0_rdata, 32'h0);
      if (q0.size() > 0 && q0[0].due < cyc) void'(q0.pop_front());
    end
    if (v1e) begin
      chk("m1_rdata", m1_rdata, q1[0].data);
      void'(q1.pop_front());
    end else begin
      chk("m1_rdata_idle", m1_rdata, 32'h0);
      if (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  // One cycle: check grants and SRAM port, record expected read return.
  task automatic step(input logic e0, input logic e1);
    logic        we;
    logic [31:0] a, d;
    exp_t        e;
    @(negedge clka);
    chk("m0_gnt", {31'h0, m0_gnt}, {31'h0, e0});
    chk("m1_gnt", {31'h0, m1_gnt}, {31'h0, e1});
    if (e0 || e1) begin
      we = e1 ? m1_we : m0_we;
      a  = e1 ? m1_addr : m0_addr;
      d  = e1 ? m1_wdata : m0_wdata;
      if (we) begin
        chk("wea_write", {31'h0, sram_wea}, 32'h1);
        chk("waddr", sram_waddr, a);
        chk("dina", sram_dina, d);
        exp_mem[a[7:0]] = d;
        last_w = a;
        last_d = d;
      end else begin
        chk("wea_read", {31'h0, sram_wea}, 32'h0);
        chk("addra", sram_addra, a);
        e.data = exp_mem[a[7:0]];
        e.due  = cyc + 1;
        if (e1) q1.push_back(e);
        else    q0.push_back(e);
        last_r = a;
      end
    end else begin
      chk("wea_idle", {31'h0, sram_wea}, 32'h0);
      chk("waddr_hold", sram_waddr, last_w);
      chk("dina_hold", sram_dina, last_d);
      chk("addra_hold", sram_addra, last_r);
    end
    @(posedge clka);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m0_gnt"}, {31'h0, m0_gnt}, 32'h0);
    chk({tag, "_m1_gnt"}, {31'h0, m1_gnt}, 32'h0);
    chk({tag, "_m0_rvalid"}, {31'h0, m0_rvalid}, 32'h0);
    chk({tag, "_m1_rvalid"}, {31'h0, m1_rvalid}, 32'h0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    chk({tag, "_wea"}, {31'h0, sram_wea}, 32'h0);
    chk({tag, "_waddr"}, sram_waddr, 32'h0);
    chk({tag, "_dina"}, sram_dina, 32'h0);
    chk({tag, "_addra"}, sram_addra, 32'h0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clka);
    @(negedge clka);
    chk_zero("init");
    @(posedge clka);
    #1;
    rstb = 1'b1;

    // M0 write then read back.
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // M1 write with M0 idle: same-cycle grant.
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234);
    step(1'b0, 1'b1);

    // Both masters reading continuously: 4 M0 grants then 1 M1 grant, twice.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step((k % 5) != 4, (k % 5) == 4);
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);

    // Read in cycle N, write same address in N+1: read sees old data.
    drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h55);
    step(1'b0, 1'b1);
    drive(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);

    // Conflicting writes: M0 wins; M1 then drops its request without effect.
    drive(1'b1, 1'b1, 32'h40, 32'hAAAA, 1'b1, 1'b1, 32'h44, 32'hBBBB);
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
    step(1'b0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);

    // Reset lands on an M0 read grant: no rvalid, outputs zero, then resume.
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clka);
    chk("pre_rst_m0_gnt", {31'h0, m0_gnt}, 32'h1);
    #1;
    rstb = 1'b0;
    last_w = 32'h0;
    last_d = 32'h0;
    last_r = 32'h0;
    #1;
    chk_zero("rst");
    @(negedge clka);
    chk_zero("rst2");
    @(posedge clka);
    #1;
    rstb = 1'b1;
    step(1'b1, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive cycles M1 may request without a grant while M0 holds the port.
REQ-002 Parameter AW, default 32: address width; DW fixed at 32.
REQ-003 clka  input  1  single clock; all state updates on its rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 m0_req / m1_req  input  1  master access request (M0 = CPU load/store, M1 = loader/debug).
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read; valid while req high.
REQ-007 m0_addr / m1_addr  input  AW  word address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_gnt / m1_gnt  output  1  request accepted this cycle (combinational from req and registered state).
REQ-010 m0_rvalid / m1_rvalid  output  1  read data valid, registered.
REQ-011 m0_rdata / m1_rdata  output  32  read data; equals sram_douta when that master's rvalid is high, else 0.
REQ-012 sram_wea  output  1  SRAM write enable.
REQ-013 sram_waddr, sram_dina  output  AW, 32  SRAM write address and data.
REQ-014 sram_addra  output  AW  SRAM read address.
REQ-015 sram_douta  input  32  SRAM read data, valid one cycle after sram_addra is presented.

Function
REQ-016 At most one of m0_gnt/m1_gnt is high in any cycle; gnt is never high without the matching req.
REQ-017 Default policy: M0 has priority; M1 is granted when m0_req = 0 or when starve_cnt = STARVE_LIMIT.
REQ-018 starve_cnt (width clog2(STARVE_LIMIT+1)) increments each cycle M1 requests and is denied, saturates at STARVE_LIMIT, and clears to 0 on any m1_gnt or on m1_req = 0.
REQ-019 A granted write drives sram_wea = 1 with the granted master's addr/wdata in the grant cycle; the write commits at that clock edge.
REQ-020 A granted read drives sram_addra = granted addr and sram_wea = 0; the granted master's rvalid is high exactly one cycle later.
REQ-021 With no grant: sram_wea = 0; sram_waddr, sram_dina and sram_addra hold their last granted values (no toggling).
REQ-022 Masters keep req/we/addr/wdata stable until gnt; a request dropped before gnt is discarded without side effects.
REQ-023 Back-to-back grants are allowed every cycle; a read granted in cycle N and a write to the same address granted in cycle N+1 return pre-write data.
REQ-024 A read-pending register (1 bit plus owner ID) records which master receives rvalid; it is overwritten every cycle.

Reset
REQ-025 While rstb = 0: gnt = 0, rvalid = 0, rdata = 0, sram_wea = 0, SRAM address/data outputs = 0, starve_cnt = 0, read-pending cleared.
REQ-026 A read granted in the cycle reset asserts never produces rvalid; after rstb deasserts, the first grant is possible in the first clock cycle.

Structure
REQ-027 Shared package sram_arb_pkg holds MST_CPU = 0, MST_LDR = 1, DW = 32 and the read-pending owner type.
REQ-028 Sub-module sram_arb_starve_ctr holds the saturating starvation counter and outputs a force_m1 flag; the arbiter instantiates it once.

Verification
REQ-029 M0 write addr 0x10 data 0xDEADBEEF, then M0 read addr 0x10 -> m0_rvalid one cycle after the read grant, m0_rdata = 0xDEADBEEF, m1_rvalid = 0.
REQ-030 M0 and M1 request continuously with STARVE_LIMIT = 4 -> M0 granted 4 cycles, then M1 granted in the 5th cycle, and the pattern repeats.
REQ-031 M1 writes 0x20 = 0x1234 with m0_req = 0 -> m1_gnt is high in the same cycle and sram_wea = 1 with sram_waddr = 0x20.
REQ-032 M0 reads 0x30 in cycle N and M1 writes 0x30 = 0x55 in cycle N+1 -> m0_rdata = old value; a later read returns 0x55.
REQ-033 rstb asserted in the same cycle as an M0 read grant -> no rvalid is produced, all outputs are 0, and normal grants resume after release.
